// File: rtl/paint_scheduler_pkg.sv
// Shared types and display geometry for the brush-stroke write scheduler.
package paint_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    color_t     color;
    logic [1:0] radius;
  } paint_cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, PAINT} paint_state_t;

endpackage

// File: rtl/paint_scheduler_cmd_fifo.sv
// Command queue between the SPI decoder and the stroke sequencer; head is read combinationally.
module cmd_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  paint_cmd_t i_data,
  output paint_cmd_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  paint_cmd_t    r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/paint_scheduler.sv
// Expands queued brush commands into clipped raster-order pixel writes, gated to blanking.
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int FIFO_DEPTH       = 4,
  parameter bit WR_IN_BLANK_ONLY = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [1:0]         cmd_radius,
  input  logic               vid_active,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic               busy,
  output logic [7:0]         drop_count
);

  localparam logic signed [COORD_W:0] X_MAX = (COORD_W+1)'(H_ACTIVE - 1);
  localparam logic signed [COORD_W:0] Y_MAX = (COORD_W+1)'(V_ACTIVE - 1);

  function automatic coord_t clamp_lo(input logic signed [COORD_W:0] v);
    return (v < 0) ? '0 : v[COORD_W-1:0];
  endfunction

  function automatic coord_t clamp_hi(input logic signed [COORD_W:0] v,
                                      input logic signed [COORD_W:0] vmax);
    return (v > vmax) ? vmax[COORD_W-1:0] : v[COORD_W-1:0];
  endfunction

  paint_state_t r_state;
  paint_cmd_t   r_cmd;
  paint_cmd_t   w_head;
  paint_cmd_t   w_in;
  coord_t       r_x0, r_x1, r_y1;
  coord_t       r_wr_x, r_wr_y;
  color_t       r_wr_color;
  logic [7:0]   r_drop;
  logic         w_full, w_empty, w_pop, w_allowed, w_oob;
  logic signed [COORD_W:0] w_rad, w_x_lo, w_x_hi, w_y_lo, w_y_hi;

  assign w_in = '{x: cmd_x, y: cmd_y, color: cmd_color, radius: cmd_radius};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_allowed = !WR_IN_BLANK_ONLY || !vid_active;
  assign w_oob     = (r_cmd.x >= coord_t'(H_ACTIVE)) || (r_cmd.y >= coord_t'(V_ACTIVE));

  // Signed one-bit-wider bounds so x-r below zero clamps instead of wrapping.
  assign w_rad  = {{(COORD_W-1){1'b0}}, r_cmd.radius};
  assign w_x_lo = $signed({1'b0, r_cmd.x}) - w_rad;
  assign w_x_hi = $signed({1'b0, r_cmd.x}) + w_rad;
  assign w_y_lo = $signed({1'b0, r_cmd.y}) - w_rad;
  assign w_y_hi = $signed({1'b0, r_cmd.y}) + w_rad;

  always_ff @(posedge clk) begin
    if (w_pop) r_cmd <= w_head;
    if (r_state == LOAD) begin
      r_x0 <= clamp_lo(w_x_lo);
      r_x1 <= clamp_hi(w_x_hi, X_MAX);
      r_y1 <= clamp_hi(w_y_hi, Y_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= '0;
      r_drop     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= LOAD;
        end
        LOAD: begin
          if (w_oob) begin
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            r_state <= IDLE;
          end else begin
            r_wr_x     <= clamp_lo(w_x_lo);
            r_wr_y     <= clamp_lo(w_y_lo);
            r_wr_color <= r_cmd.color;
            r_state    <= PAINT;
          end
        end
        PAINT: begin
          // Blocked cycles hold everything, so no pixel is skipped or repeated.
          if (w_allowed) begin
            if (r_wr_x < r_x1) begin
              r_wr_x <= r_wr_x + 1'b1;
            end else if (r_wr_y < r_y1) begin
              r_wr_x <= r_x0;
              r_wr_y <= r_wr_y + 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_en      = (r_state == PAINT) && w_allowed;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign wr_color   = r_wr_color;
  assign cmd_ready  = !w_full;
  assign busy       = !w_empty || (r_state != IDLE);
  assign drop_count = r_drop;

endmodule

// File: doc/paint_scheduler.md
Name: paint_scheduler

Overview:
Sequences brush-stroke writes into the pixel store. Decoded paint commands (centre x/y, colour code, brush radius) are queued in a small FIFO. Each command is expanded into a clipped square of per-pixel writes in raster order. Writes are gated to VGA blanking so the frame being scanned out never tears. Sits between the SPI command decoder and the pixel store write port.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of two, >=2)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
COORD_W, 10, coordinate width
COLOR_W, 3, colour code width
WR_IN_BLANK_ONLY, 1, 1 = write only while vid_active=0; 0 = write every PAINT cycle

Ports:
clk  in  1  pixel clock (25.175 MHz)
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_x  in  COORD_W  brush centre x
cmd_y  in  COORD_W  brush centre y
cmd_color  in  COLOR_W  colour code
cmd_radius  in  2  brush half-width r; square side is 2r+1
vid_active  in  1  high while the VGA controller scans the visible region
wr_en  out  1  pixel store write strobe
wr_x  out  COORD_W  write x
wr_y  out  COORD_W  write y
wr_color  out  COLOR_W  write colour code
busy  out  1  FIFO non-empty or state != IDLE
drop_count  out  8  saturating count of discarded out-of-range commands

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; state IDLE.
  - wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, drop_count=0.
  - cmd_ready=1 (it is !full).
  - Reset mid-PAINT aborts the stroke; no further writes.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - Pop only in IDLE when non-empty.
  - No bypass: a push into an empty FIFO becomes visible to the FSM the next cycle.
  - Push and pop in the same cycle are both honoured; level is unchanged.
- FSM states: IDLE, LOAD, PAINT.
- IDLE:
  - If the FIFO is non-empty, pop the head into command registers and go to LOAD.
- LOAD:
  - If cmd_x>=H_ACTIVE or cmd_y>=V_ACTIVE: discard, drop_count+=1 (saturates at 255), go to IDLE.
  - Otherwise compute bounds in COORD_W+1-bit signed arithmetic:
    - x0=max(x-r,0), x1=min(x+r,H_ACTIVE-1)
    - y0=max(y-r,0), y1=min(y+r,V_ACTIVE-1)
  - Load wr_x=x0, wr_y=y0, wr_color=colour, then go to PAINT.
- PAINT:
  - allowed = !WR_IN_BLANK_ONLY || !vid_active.
  - wr_en = (state==PAINT) && allowed. This is combinational from vid_active.
  - wr_x, wr_y and wr_color are registered.
  - On each allowed cycle, advance:
    - if wr_x<x1: wr_x++
    - else: wr_x=x0 and wr_y++
  - After the write at (x1,y1), go to IDLE; wr_x/wr_y/wr_color hold their last values.
  - On cycles that are not allowed: no write; all registers hold. No pixel is skipped or duplicated.
- Latency:
  - Command pushed at the edge ending cycle t, FSM idle: pop in cycle t+1, LOAD in t+2, first wr_en in t+3 (if allowed).
  - A full stroke takes (x1-x0+1)*(y1-y0+1) allowed cycles.
  - Back-to-back commands incur 2 cycles (IDLE+LOAD) between strokes.
- Boundaries:
  - r=0 gives exactly one write.
  - Clipping never wraps; coordinates stay within 0..H_ACTIVE-1 and 0..V_ACTIVE-1.
  - When full, cmd_ready=0 and an asserted cmd_valid is held off, not lost.

Decomposition:
- Package paint_pkg holds:
  - constants H_ACTIVE, V_ACTIVE, COORD_W, COLOR_W
  - typedef color_t
  - struct paint_cmd_t {x, y, color, radius}
  - enum paint_state_t {IDLE, LOAD, PAINT}
- Sub-module cmd_fifo: synchronous FIFO of paint_cmd_t, parameter DEPTH, with full/empty/push/pop, async active-low reset.
- Bounds computation and raster stepping stay in paint_scheduler.

Test Plan:
1. Assert reset_n=0 mid-PAINT with 2 commands queued -> wr_en=0 immediately, busy=0, cmd_ready=1, drop_count=0; no writes after release.
2. Single command x=100, y=50, r=0, color=5, vid_active=0, pushed at t -> exactly one wr_en, at t+3, with (100,50,5); busy low from t+4.
3. x=10, y=20, r=1 -> 9 consecutive writes: (9,19),(10,19),(11,19),(9,20),(10,20),(11,20),(9,21),(10,21),(11,21).
4. Corner clipping:
   - (0,0), r=3 -> 16 writes covering x,y in 0..3.
   - (639,479), r=2 -> 9 writes covering x 637..639, y 477..479.
5. Blanking gating with r=1: toggle vid_active=1 for 5 cycles after the 4th write -> wr_en stays 0 and wr_x/wr_y hold (10,20); after release, the remaining 5 writes complete with none missed or repeated.
6. Queue saturation and drop:
   - Hold vid_active=1 and push 6 commands -> 1 is taken into PAINT, 4 are queued, then cmd_ready=0 and the 6th is stalled.
   - A command with x=700 -> produces no writes and drop_count becomes 1.
